rr_arb5: RTL and testbench

RR_ARB5 -- requirements
Module: rr_arb5

---
 rtl/rr_arb_pkg.sv | 21 ++
 rtl/rr_pick5.sv | 29 ++
 rtl/rr_arb5.sv | 82 ++++++++
 tb/tb_rr_arb5.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared constants, state encoding and pointer helper for the 5-way round-robin arbiter.
// No timing of its own; no backpressure.
package rr_arb_pkg;

  localparam int N_REQ = 5;
  localparam int ID_W  = 3;
  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  // Pointer starts at the last requester so requester 0 wins the first search.
  localparam logic [ID_W-1:0] PTR_RST = 3'd4;

  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
    return (i >= ID_W'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick5.sv
// Rotating priority search: first set request bit strictly after ptr, wrapping; ptr itself lowest.
// Purely combinational, zero latency; no backpressure.
module rr_pick5
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] win,
  output logic [ID_W-1:0]  win_id,
  output logic             found
);

  logic [ID_W-1:0] idx;

  always_comb begin
    idx    = ptr;
    win_id = '0;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = next_idx(idx);
      if (!found && req[idx]) begin
        found  = 1'b1;
        win_id = idx;
      end
    end
    win = found ? (N_REQ'(1) << win_id) : '0;
  end

endmodule

// File: rtl/rr_arb5.sv
// 5-way round-robin arbiter, registered one-hot grant; optional hold timeout via RR_ARB5_TIMEOUT_EN.
// Grant 1 cycle after request sampled; requesters wait (level-held REQ) until granted.
module rr_arb5
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             C,
  input  logic             RB,
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] GNT,
  output logic             GNT_VLD,
  output logic [ID_W-1:0]  GNT_ID,
  output logic [CNT_W-1:0] BUSY_CNT
);

`ifdef RR_ARB5_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  state_t          state;
  logic [ID_W-1:0] ptr;

  logic [N_REQ-1:0] win;
  logic [ID_W-1:0]  win_id;
  logic             found;

  rr_pick5 u_pick (
    .req    (REQ),
    .ptr    (ptr),
    .win    (win),
    .win_id (win_id),
    .found  (found)
  );

  logic owner_req;
  logic others;
  logic timeout;
  logic do_load;
  logic do_drop;

  // While owning, ptr equals the owner, so the search naturally ranks the owner last;
  // the limit is tested as >= so a requester arriving after the limit is not starved.
  always_comb begin
    owner_req = |(REQ & GNT);
    others    = |(REQ & ~GNT);
    timeout   = TO_EN && (state == ST_OWN) && (BUSY_CNT >= HOLD_LIM) && others;
    do_load   = found && ((state == ST_IDLE) || !owner_req || timeout);
    do_drop   = (state == ST_OWN) && !owner_req && !found;
  end

  always_ff @(posedge C) begin
    if (!RB) begin
      state    <= ST_IDLE;
      ptr      <= PTR_RST;
      GNT      <= '0;
      GNT_VLD  <= 1'b0;
      GNT_ID   <= '0;
      BUSY_CNT <= '0;
    end else if (do_load) begin
      state    <= ST_OWN;
      ptr      <= win_id;
      GNT      <= win;
      GNT_VLD  <= 1'b1;
      GNT_ID   <= win_id;
      BUSY_CNT <= CNT_W'(1);
    end else if (do_drop) begin
      state    <= ST_IDLE;
      GNT      <= '0;
      GNT_VLD  <= 1'b0;
      GNT_ID   <= '0;
      BUSY_CNT <= '0;
    end else if (state == ST_OWN && BUSY_CNT != '1) begin
      BUSY_CNT <= BUSY_CNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rr_arb5.sv
// Directed scoreboard bench for rr_arb5: stimulus pushes expected outputs, monitor pops and compares.
// Checks the expectations of both builds, selected by RR_ARB5_TIMEOUT_EN.
module tb_rr_arb5;

  logic       C = 1'b0;
  logic       RB = 1'b0;
  logic [4:0] REQ = 5'b0;
  logic [4:0] GNT;
  logic       GNT_VLD;
  logic [2:0] GNT_ID;
  logic [7:0] BUSY_CNT;

  rr_arb5 #(.MAX_HOLD(4)) dut (
    .C        (C),
    .RB       (RB),
    .REQ      (REQ),
    .GNT      (GNT),
    .GNT_VLD  (GNT_VLD),
    .GNT_ID   (GNT_ID),
    .BUSY_CNT (BUSY_CNT)
  );

  always #5 C = ~C;

  typedef struct packed {
    logic [4:0] gnt;
    logic       vld;
    logic [2:0] id;
    logic [7:0] busy;
  } exp_t;

  exp_t  sb[$];
  string nm_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  task automatic step(input logic [4:0] req, input logic rb, input logic [4:0] g,
                      input logic [2:0] id, input int busy, input string nm);
    exp_t e;
    @(negedge C);
    REQ = req;
    RB  = rb;
    e.gnt  = g;
    e.vld  = (g != 5'b0);
    e.id   = id;
    e.busy = busy[7:0];
    sb.push_back(e);
    nm_q.push_back(nm);
  endtask

  // Monitor: invariants every cycle, then the queued expectation for this edge.
  initial begin
    logic [4:0] req_s;
    logic       rb_s;
    exp_t       e;
    exp_t       act;
    string      nm;
    forever begin
      @(posedge C);
      req_s = REQ;
      rb_s  = RB;
      #1;
      if (!$onehot0(GNT)) begin
        miscompares++;
        $display("FAIL inv_onehot: gnt=%b, want one-hot or zero", GNT);
      end
      if (GNT_VLD !== (|GNT)) begin
        miscompares++;
        $display("FAIL inv_vld: vld=%b, want %b", GNT_VLD, |GNT);
      end
      if (GNT_VLD ? (GNT !== (5'b00001 << GNT_ID)) : (GNT_ID !== 3'd0)) begin
        miscompares++;
        $display("FAIL inv_id: id=%0d gnt=%b, want id consistent with gnt", GNT_ID, GNT);
      end
      if (rb_s && GNT != 5'b0 && (GNT & req_s) == 5'b0) begin
        miscompares++;
        $display("FAIL inv_req: gnt=%b, req sampled=%b, want granted bit requested", GNT, req_s);
      end
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        nm  = nm_q.pop_front();
        act = {GNT, GNT_VLD, GNT_ID, BUSY_CNT};
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL %s: got gnt=%b vld=%b id=%0d busy=%0d, want gnt=%b vld=%b id=%0d busy=%0d",
                   nm, GNT, GNT_VLD, GNT_ID, BUSY_CNT, e.gnt, e.vld, e.id, e.busy);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    logic [4:0] ord [6];
    logic [2:0] oid [6];
    logic [4:0] r;
    ord = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    oid = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

    // Reset ignores requests
    step(5'b11111, 1'b0, 5'b00000, 3'd0, 0, "reset_a");
    step(5'b11111, 1'b0, 5'b00000, 3'd0, 0, "reset_b");
    // Single requester, 1-cycle latency, counter runs
    step(5'b00000, 1'b1, 5'b00000, 3'd0, 0, "idle");
    step(5'b00001, 1'b1, 5'b00001, 3'd0, 1, "first_grant");
    step(5'b00001, 1'b1, 5'b00001, 3'd0, 2, "busy2");
    step(5'b00001, 1'b1, 5'b00001, 3'd0, 3, "busy3");
    step(5'b00000, 1'b1, 5'b00000, 3'd0, 0, "release_idle");
    // Full rotation from pointer reset value, each owner drops for one edge
    step(5'b00000, 1'b0, 5'b00000, 3'd0, 0, "reset_rot");
    for (int i = 0; i < 6; i++) begin
      for (int c = 1; c <= 3; c++) begin
        r = (c == 1 && i > 0) ? (5'b11111 & ~ord[i-1]) : 5'b11111;
        step(r, 1'b1, ord[i], oid[i], c, "rotate");
      end
    end
    // Owner 2 releases alone, pointer stays at 2
    step(5'b00100, 1'b1, 5'b00100, 3'd2, 1, "to_owner2");
    step(5'b00100, 1'b1, 5'b00100, 3'd2, 2, "owner2_hold");
    step(5'b00000, 1'b1, 5'b00000, 3'd0, 0, "owner2_release");
    step(5'b11111, 1'b1, 5'b01000, 3'd3, 1, "ptr_kept_2");
    step(5'b00110, 1'b1, 5'b00010, 3'd1, 1, "wrap_search");
    step(5'b01101, 1'b1, 5'b00100, 3'd2, 1, "next_after_1");
    step(5'b01001, 1'b1, 5'b01000, 3'd3, 1, "owner2_rel");
    // Reset mid-grant
    step(5'b11111, 1'b1, 5'b01000, 3'd3, 2, "hold_3");
    step(5'b11111, 1'b0, 5'b00000, 3'd0, 0, "reset_mid_grant");
    step(5'b11111, 1'b1, 5'b00001, 3'd0, 1, "after_reset_req0");
    // Hold limit scenario with MAX_HOLD=4
    step(5'b00000, 1'b0, 5'b00000, 3'd0, 0, "reset_to");
    step(5'b00010, 1'b1, 5'b00010, 3'd1, 1, "to_c1");
    step(5'b01010, 1'b1, 5'b00010, 3'd1, 2, "to_c2");
    step(5'b01010, 1'b1, 5'b00010, 3'd1, 3, "to_c3");
    step(5'b01010, 1'b1, 5'b00010, 3'd1, 4, "to_c4");
`ifdef RR_ARB5_TIMEOUT_EN
    step(5'b01010, 1'b1, 5'b01000, 3'd3, 1, "preempt");
    for (int c = 2; c <= 4; c++) step(5'b01010, 1'b1, 5'b01000, 3'd3, c, "owner3_hold");
    step(5'b01010, 1'b1, 5'b00010, 3'd1, 1, "preempt_back");
    for (int c = 2; c <= 6; c++) step(5'b00010, 1'b1, 5'b00010, 3'd1, c, "no_other_hold");
`else
    for (int n = 5; n <= 260; n++)
      step(5'b01010, 1'b1, 5'b00010, 3'd1, (n > 255) ? 255 : n, "no_preempt");
`endif
    repeat (3) @(negedge C);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
